// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer
//   Tile-based playfield renderer with a processor-mapped board RAM and palette.
//   Each board byte selects a palette entry (low 3 bits) for one tile. A two-stage
//   pipeline, advanced by pix_en, turns pixel coordinates into an RGB332 colour.
//   A clear sequencer zeroes the board after every reset and on a write to 0xFF.
//
//   Optional build macro: VGA_TILE_GRID_EN draws GRID_COLOR on the first pixel
//   row/column of every playfield tile.
//
// Ports
//   clk, rst             clock, synchronous active-low reset
//   pix_en               pixel strobe; render pipeline advances only when high
//   x, y, video_on       current pixel coordinate and visible-area flag
//   pico_addr/data_in    processor address and write data
//   pico_write_strobe    write enable (same-cycle effect)
//   pico_read_strobe     informational only
//   pico_data_out        registered read data for last cycle's pico_addr
//   vga_out              RGB332 pixel colour
//   clr_busy             high while the clear sequencer runs
module vga_tile_renderer #(
    parameter int         COLS       = 10,
    parameter int         ROWS       = 22,
    parameter int         X_ORG      = 15,
    parameter int         Y_ORG      = 0,
    parameter int         TILE_SHIFT = 4,
    parameter logic [7:0] BG_COLOR   = 8'h49,
    parameter logic [7:0] GRID_COLOR = 8'h92
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       video_on,
    input  logic [7:0] pico_addr,
    input  logic [7:0] pico_data_in,
    input  logic       pico_write_strobe,
    input  logic       pico_read_strobe,
    output logic [7:0] pico_data_out,
    output logic [7:0] vga_out,
    output logic       clr_busy
);
    localparam int         N    = COLS * ROWS;
    localparam int         AW   = $clog2(N);
    localparam logic [7:0] LAST = 8'(N - 1);
    localparam logic [7:0] PAL_RST [8] = '{8'h00, 8'h03, 8'hE3, 8'hE0,
                                           8'h1C, 8'h1B, 8'hFC, 8'hC4};

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          boot_q;          // set through reset: forces a clear on release
    logic [7:0]    ram_q [N];
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [7:0]    ram_wdata;
    logic [7:0]    pal_q [8];
    logic [7:0]    pal_d [8];
    logic [7:0]    rdata_q, rdata_d;
    logic          board_hit, pal_hit, clr_cmd;

    logic [15:0]   tx, ty, idx;
    logic          in_x, in_y;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_word;
    logic          vis_q, vis_d, in_field_q, in_field_d;
    logic [2:0]    cidx_q, cidx_d;
    logic [7:0]    vga_q, vga_d;
`ifdef VGA_TILE_GRID_EN
    logic          grid_q, grid_d;
`endif

    assign board_hit = {1'b0, pico_addr} < 9'(N);
    assign pal_hit   = pico_addr[7:3] == 5'b11110;
    assign clr_cmd   = pico_write_strobe && (pico_addr == 8'hFF);
    assign clr_busy  = (state_q == CLEAR);

    // Clear sequencer; owns the single RAM write port while clearing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ram_we    = 1'b0;
        ram_waddr = pico_addr[AW-1:0];
        ram_wdata = pico_data_in;
        case (state_q)
            IDLE: begin
                if (clr_cmd || boot_q) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (pico_write_strobe && board_hit) begin
                    ram_we = 1'b1;
                end
            end
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = cnt_q[AW-1:0];
                ram_wdata = '0;
                if (clr_cmd)             cnt_d   = '0;
                else if (cnt_q == LAST)  state_d = IDLE;
                else                     cnt_d   = cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pal_d = pal_q;
        if (pico_write_strobe && pal_hit) pal_d[pico_addr[2:0]] = pico_data_in;
    end

    // Read data reflects contents before any write landing on the same edge.
    always_comb begin
        rdata_d = '0;
        if (board_hit)               rdata_d = ram_q[pico_addr[AW-1:0]];
        else if (pal_hit)            rdata_d = pal_q[pico_addr[2:0]];
        else if (pico_addr == 8'hFE) rdata_d = {7'd0, clr_busy};
    end

    // Render pipeline. 16-bit tile arithmetic keeps tx < X_ORG from wrapping
    // into the field; the RAM index is forced to 0 outside the field.
    always_comb begin
        tx      = 16'(x >> TILE_SHIFT);
        ty      = 16'(y >> TILE_SHIFT);
        in_x    = (tx >= 16'(X_ORG)) && (tx < 16'(X_ORG + COLS));
        in_y    = (ty >= 16'(Y_ORG)) && (ty < 16'(Y_ORG + ROWS));
        idx     = (ty - 16'(Y_ORG)) * 16'(COLS) + (tx - 16'(X_ORG));
        rd_addr = (in_x && in_y) ? idx[AW-1:0] : '0;
        rd_word = ram_q[rd_addr];

        vis_d      = vis_q;
        in_field_d = in_field_q;
        cidx_d     = cidx_q;
        vga_d      = vga_q;
`ifdef VGA_TILE_GRID_EN
        grid_d     = grid_q;
`endif
        if (pix_en) begin
            vis_d      = video_on;
            in_field_d = video_on && in_x && in_y;
            cidx_d     = rd_word[2:0];
            if (!vis_q)          vga_d = 8'h00;
            else if (in_field_q) vga_d = pal_q[cidx_q];
            else                 vga_d = BG_COLOR;
`ifdef VGA_TILE_GRID_EN
            grid_d = video_on && in_x && in_y &&
                     ((x[TILE_SHIFT-1:0] == '0) || (y[TILE_SHIFT-1:0] == '0));
            if (vis_q && in_field_q && grid_q) vga_d = GRID_COLOR;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            boot_q     <= 1'b1;
            rdata_q    <= '0;
            pal_q      <= PAL_RST;
            vis_q      <= 1'b0;
            in_field_q <= 1'b0;
            cidx_q     <= '0;
            vga_q      <= '0;
`ifdef VGA_TILE_GRID_EN
            grid_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            boot_q     <= 1'b0;
            rdata_q    <= rdata_d;
            pal_q      <= pal_d;
            vis_q      <= vis_d;
            in_field_q <= in_field_d;
            cidx_q     <= cidx_d;
            vga_q      <= vga_d;
`ifdef VGA_TILE_GRID_EN
            grid_q     <= grid_d;
`endif
        end
    end

    // Board RAM: no reset, the clear sequencer initialises it.
    always_ff @(posedge clk) begin
        if (rst && ram_we) ram_q[ram_waddr] <= ram_wdata;
    end

    assign pico_data_out = rdata_q;
    assign vga_out       = vga_q;

    logic unused_ok;
`ifdef VGA_TILE_GRID_EN
    assign unused_ok = ^{pico_read_strobe, rd_word[7:3], idx[15:AW]};
`else
    assign unused_ok = ^{pico_read_strobe, rd_word[7:3], idx[15:AW], GRID_COLOR};
`endif

endmodule

// File: tb/tb_vga_tile_renderer.sv
module tb_vga_tile_renderer;
    localparam int N = 220;
    localparam logic [7:0] PAL_DEF [8] = '{8'h00, 8'h03, 8'hE3, 8'hE0,
                                           8'h1C, 8'h1B, 8'hFC, 8'hC4};

    logic       clk = 1'b0;
    logic       rst, pix_en, video_on, pico_write_strobe, pico_read_strobe;
    logic [9:0] x, y;
    logic [7:0] pico_addr, pico_data_in, pico_data_out, vga_out;
    logic       clr_busy;

    always #5 clk = ~clk;

    vga_tile_renderer dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .x(x), .y(y), .video_on(video_on),
        .pico_addr(pico_addr), .pico_data_in(pico_data_in),
        .pico_write_strobe(pico_write_strobe), .pico_read_strobe(pico_read_strobe),
        .pico_data_out(pico_data_out), .vga_out(vga_out), .clr_busy(clr_busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; logic [7:0] exp; } exp_t;
    exp_t vq[$];
    exp_t rq[$];
    exp_t bq[$];
    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] mr [N];
    logic [7:0] mpal [8];
    int         busy_lo = 0, busy_hi = 0;
    logic [7:0] disp = 8'h00, pend = 8'h00;
    logic       prev_rst = 1'b0;

    function automatic logic m_busy(int c);
        return (c >= busy_lo) && (c < busy_hi);
    endfunction

    function automatic logic [7:0] ref_color(int px, int py, logic vo);
        int tx, ty;
        if (!vo) return 8'h00;
        tx = px / 16;
        ty = py / 16;
        if (tx >= 15 && tx < 25 && ty < 22) begin
`ifdef VGA_TILE_GRID_EN
            if (px % 16 == 0 || py % 16 == 0) return 8'h92;
`endif
            return mpal[int'(mr[ty * 10 + tx - 15] % 8)];
        end
        return 8'h49;
    endfunction

    function automatic logic [7:0] ref_read(int a, int c);
        if (a < N)                return mr[a];
        if (a >= 'hF0 && a <= 'hF7) return mpal[a - 'hF0];
        if (a == 'hFE)            return {7'd0, m_busy(c)};
        return 8'h00;
    endfunction

    // Advance the reference by one clock, queue the expected outputs, wait the edge.
    task automatic tick();
        int         cur;
        logic [7:0] rexp;
        logic       do_rd;
        cur = cyc;
        if (!rst) begin
            if (busy_hi > cur + 1) busy_hi = cur + 1;
            mpal  = PAL_DEF;
            disp  = 8'h00;
            pend  = 8'h00;
            rexp  = 8'h00;
            do_rd = 1'b1;
        end else begin
            do_rd = !pico_write_strobe &&
                    !((int'(pico_addr) < N) && (m_busy(cur) || !prev_rst));
            rexp  = ref_read(int'(pico_addr), cur);
            if (!prev_rst) begin
                busy_lo = cur + 1;
                busy_hi = cur + 221;
                foreach (mr[i]) mr[i] = 8'h00;
            end else if (pico_write_strobe) begin
                if (pico_addr == 8'hFF) begin
                    if (!m_busy(cur)) busy_lo = cur + 1;
                    busy_hi = cur + 221;
                    foreach (mr[i]) mr[i] = 8'h00;
                end else if (int'(pico_addr) < N) begin
                    if (!m_busy(cur)) mr[pico_addr] = pico_data_in;
                end else if (pico_addr >= 8'hF0 && pico_addr <= 8'hF7) begin
                    mpal[pico_addr - 8'hF0] = pico_data_in;
                end
            end
            if (pix_en) begin
                disp = pend;
                pend = ref_color(int'(x), int'(y), video_on);
            end
        end
        prev_rst = rst;
        vq.push_back('{due: cur + 1, exp: disp});
        if (do_rd) rq.push_back('{due: cur + 1, exp: rexp});
        bq.push_back('{due: cur + 1, exp: {7'd0, m_busy(cur + 1)}});
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops whatever is due this cycle and compares.
    always @(negedge clk) begin
        exp_t e;
        if (vq.size() > 0 && vq[0].due <= cyc) begin
            e = vq.pop_front();
            checks++;
            if (e.due != cyc || vga_out !== e.exp) begin
                errors++;
                $display("FAIL vga_out cyc=%0d got=%h want=%h due=%0d", cyc, vga_out, e.exp, e.due);
            end
        end
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            e = rq.pop_front();
            checks++;
            if (e.due != cyc || pico_data_out !== e.exp) begin
                errors++;
                $display("FAIL pico_data_out cyc=%0d got=%h want=%h due=%0d", cyc, pico_data_out, e.exp, e.due);
            end
        end
        if (bq.size() > 0 && bq[0].due <= cyc) begin
            e = bq.pop_front();
            checks++;
            if (e.due != cyc || clr_busy !== e.exp[0]) begin
                errors++;
                $display("FAIL clr_busy cyc=%0d got=%b want=%b due=%0d", cyc, clr_busy, e.exp[0], e.due);
            end
        end
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic idle();
        pico_write_strobe = 1'b0;
        pico_addr         = 8'hE0;
        pico_data_in      = 8'h00;
    endtask

    task automatic wr(logic [7:0] a, logic [7:0] d);
        pico_write_strobe = 1'b1;
        pico_addr         = a;
        pico_data_in      = d;
        tick();
        idle();
    endtask

    task automatic rd(logic [7:0] a);
        pico_write_strobe = 1'b0;
        pico_addr         = a;
        tick();
        idle();
    endtask

    task automatic pix(int px, int py, logic vo);
        x        = 10'(px);
        y        = 10'(py);
        video_on = vo;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        mpal = PAL_DEF;
        foreach (mr[i]) mr[i] = 8'h00;
        rst = 1'b0; pix_en = 1'b0; video_on = 1'b0; x = '0; y = '0;
        pico_read_strobe = 1'b0;
        idle();

        repeat (4) begin
            tick();
            check("rst_vga", vga_out, 8'h00);
            check("rst_rdata", pico_data_out, 8'h00);
            check("rst_busy", clr_busy, 1'b0);
        end

        // Reset release: automatic clear
        rst = 1'b1;
        tick();
        n = 0;
        while (clr_busy && n < 1000) begin tick(); n++; end
        check("boot_busy_len", n, 220);

        for (int a = 0; a < N; a++) rd(8'(a));
        rd(8'hFE);
        for (int a = 'hF0; a <= 'hF7; a++) rd(8'(a));
        rd(8'hE0);
        rd(8'hFF);

        // Single tile render
        wr(8'd21, 8'h05);
        wr(8'd23, 8'h05);
        pix_en = 1'b1;
        pix(256, 32, 1'b1); tick();
        check("tile_256_32", vga_out, 8'h1B);
        pix(288, 32, 1'b1); tick();
        check("tile_288_32", vga_out, 8'h1B);
        pix(239, 32, 1'b1); tick();
        check("bg_239", vga_out, 8'h49);
        pix(256, 32, 1'b0); tick();
        check("blank", vga_out, 8'h00);
        pix_en = 1'b0;

        // Palette override
        wr(8'hF5, 8'hFF);
        rd(8'hF5);
        pix_en = 1'b1;
        pix(256, 32, 1'b1); tick();
        check("pal_override", vga_out, 8'hFF);

        // Hold with pix_en low
        pix_en = 1'b0;
        wr(8'd10, 8'h03);
        pix_en = 1'b1;
        pix(240, 16, 1'b1); tick();
`ifdef VGA_TILE_GRID_EN
        check("grid_240_16", vga_out, 8'h92);
`else
        check("tile_240_16", vga_out, 8'hE0);
`endif
        pix_en = 1'b0;
        for (int i = 0; i < 10; i++) pix(300 + i, 48, 1'b1);
        pix_en = 1'b1;
        pix(0, 0, 1'b0); pix(0, 0, 1'b0);
        pix_en = 1'b0;

        // Randomised traffic and rendering
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 25; i++) begin
                case ($urandom_range(0, 4))
                    0: wr(8'($urandom_range(0, N - 1)), 8'($urandom));
                    1: wr(8'($urandom_range('hF0, 'hF7)), 8'($urandom));
                    2: rd(8'($urandom_range(0, 255)));
                    3: rd(8'($urandom_range(0, N - 1)));
                    default: wr(8'($urandom_range('hDC, 'hFE)), 8'($urandom));
                endcase
            end
            for (int i = 0; i < 60; i++) begin
                pix_en = ($urandom_range(0, 9) < 7);
                pix($urandom_range(200, 440), $urandom_range(0, 400), $urandom_range(0, 7) != 0);
            end
            pix_en = 1'b1;
            pix(0, 0, 1'b0); pix(0, 0, 1'b0);
            pix_en = 1'b0;
        end

        // Clear restart, blocked board write, accepted palette write
        wr(8'hFF, 8'h00);
        n = 0;
        while (clr_busy && n < 2000) begin
            if (n == 49)       begin pico_write_strobe = 1'b1; pico_addr = 8'hFF; pico_data_in = 8'h00; end
            else if (n == 100) begin pico_write_strobe = 1'b1; pico_addr = 8'd3;  pico_data_in = 8'h07; end
            else if (n == 120) begin pico_write_strobe = 1'b1; pico_addr = 8'hF2; pico_data_in = 8'h55; end
            else idle();
            tick();
            n++;
        end
        idle();
        check("restart_busy_len", n, 270);
        rd(8'd3);
        check("addr3_cleared", pico_data_out, 8'h00);
        rd(8'hF2);
        check("pal2_during_clear", pico_data_out, 8'h55);
        rd(8'hFE);

        // Reset in the middle of a clear
        wr(8'hFF, 8'h00);
        repeat (30) tick();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        n = 0;
        while (clr_busy && n < 1000) begin tick(); n++; end
        check("rst_restart_busy_len", n, 220);
        rd(8'hF2);
        check("pal2_reloaded", pico_data_out, 8'hE3);
        rd(8'd21);

        idle();
        repeat (3) tick();
        @(negedge clk);
        #1;
        check("queue_drain", vq.size() + rq.size() + bq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
